// File: rtl/line_feeder_if.sv
// Groups the pixel stream, template memory read port and line output bus of line_feeder.
// Pure wiring, adds no latency.
// The pixel stream is valid/ready; the template port is a fixed one-cycle read; the line output has no backpressure.
interface line_feeder_if #(
  parameter int PIXEL_SIZE      = 8,
  parameter int LINE_SIZE       = 8,
  parameter int NUM_TEMPLATES   = 4,
  parameter int TEMPLATE_HEIGHT = 8
);
  logic                                                     start;
  logic [PIXEL_SIZE-1:0]                                    pix_in;
  logic                                                     pix_valid;
  logic                                                     pix_ready;
  logic                                                     tmpl_rd_en;
  logic [$clog2(TEMPLATE_HEIGHT)-1:0]                       tmpl_rd_addr;
  logic [LINE_SIZE-1:0][NUM_TEMPLATES-1:0][PIXEL_SIZE-1:0]  tmpl_rd_data;
  logic [LINE_SIZE-1:0][PIXEL_SIZE-1:0]                     I_out_line;
  logic [LINE_SIZE-1:0][NUM_TEMPLATES-1:0][PIXEL_SIZE-1:0]  T_out_line;
  logic                                                     line_valid;
  logic                                                     last_line;
  logic                                                     busy;
  logic                                                     done;

  // Requester side: issues start, streams pixels and serves template reads.
  modport master (
    output start, pix_in, pix_valid, tmpl_rd_data,
    input  pix_ready, tmpl_rd_en, tmpl_rd_addr, I_out_line, T_out_line,
    input  line_valid, last_line, busy, done
  );

  // Feeder side.
  modport slave (
    input  start, pix_in, pix_valid, tmpl_rd_data,
    output pix_ready, tmpl_rd_en, tmpl_rd_addr, I_out_line, T_out_line,
    output line_valid, last_line, busy, done
  );
endinterface

// File: rtl/line_feeder.sv
// Assembles serial pixels into image lines and pairs each with its template row for the correlator.
// The last pixel of a line accepted in cycle n gives line_valid in cycle n+3.
// pix_ready is high only while filling a line; the line output cannot be stalled.
module line_feeder #(
  parameter int PIXEL_SIZE      = 8,
  parameter int LINE_SIZE       = 8,
  parameter int NUM_TEMPLATES   = 4,
  parameter int TEMPLATE_HEIGHT = 8
) (
  input  logic          CLK,
  input  logic          RST_N,
  line_feeder_if.slave  bus
);

  localparam int COL_W = (LINE_SIZE > 1) ? $clog2(LINE_SIZE) : 1;
  localparam int ROW_W = $clog2(TEMPLATE_HEIGHT);

  typedef enum logic [2:0] {IDLE, FILL, FETCH, WAIT, ISSUE, DONE} state_t;

  state_t                               state;
  state_t                               state_nxt;
  logic [COL_W-1:0]                     col;
  logic [ROW_W-1:0]                     row;
  logic [LINE_SIZE-1:0][PIXEL_SIZE-1:0] iline;
  logic                                 last_col;
  logic                                 last_row;

  assign last_col         = (col == COL_W'(LINE_SIZE - 1));
  assign last_row         = (row == ROW_W'(TEMPLATE_HEIGHT - 1));
  assign bus.tmpl_rd_addr = row;

  // State register; reset abandons any window in progress.
  always_ff @(posedge CLK) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and the Moore-style control outputs.
  always_comb begin
    state_nxt      = state;
    bus.pix_ready  = 1'b0;
    bus.tmpl_rd_en = 1'b0;
    bus.line_valid = 1'b0;
    bus.last_line  = 1'b0;
    bus.done       = 1'b0;
    bus.busy       = (state != IDLE);
    case (state)
      IDLE:  if (bus.start) state_nxt = FILL;
      FILL: begin
        bus.pix_ready = 1'b1;
        if (bus.pix_valid && last_col) state_nxt = FETCH;
      end
      FETCH: begin
        bus.tmpl_rd_en = 1'b1;
        state_nxt      = WAIT;
      end
      WAIT:  state_nxt = ISSUE;
      ISSUE: begin
        bus.line_valid = 1'b1;
        bus.last_line  = last_row;
        state_nxt      = last_row ? DONE : FILL;
      end
      DONE: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counters, line assembly and the registered output lines.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      row            <= '0;
      col            <= '0;
      iline          <= '0;
      bus.I_out_line <= '0;
      bus.T_out_line <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            row <= '0;
            col <= '0;
          end
        end
        FILL: begin
          if (bus.pix_valid) begin
            iline[col] <= bus.pix_in;
            col        <= last_col ? '0 : col + COL_W'(1);
          end
        end
        WAIT: begin
          // Template read data arrives exactly one cycle after the FETCH strobe.
          bus.I_out_line <= iline;
          bus.T_out_line <= bus.tmpl_rd_data;
        end
        ISSUE: begin
          // Row holds at its maximum on the last line; DONE brings it back to 0.
          if (!last_row) row <= row + ROW_W'(1);
        end
        DONE:    row <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_line_feeder.sv
// Self-checking bench for line_feeder: scenario table plus randomized windows against a line-level model.
// Checks latency from the last accepted pixel of each line to line_valid.
// Drives pix_valid with gaps and during non-FILL states to exercise stalls.
module tb_line_feeder;
  localparam int P  = 8;
  localparam int L  = 8;
  localparam int K  = 4;
  localparam int H  = 8;
  localparam int TW = 256;

  logic CLK;
  logic RST_N;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;

  line_feeder_if #(.PIXEL_SIZE(P), .LINE_SIZE(L), .NUM_TEMPLATES(K), .TEMPLATE_HEIGHT(H)) bus ();

  line_feeder #(.PIXEL_SIZE(P), .LINE_SIZE(L), .NUM_TEMPLATES(K), .TEMPLATE_HEIGHT(H)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus.slave)
  );

  initial CLK = 0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  // Template memory: row data appears one cycle after the strobe, junk otherwise.
  logic [L-1:0][K-1:0][P-1:0] mem [H];
  always @(posedge CLK) begin
    if (bus.tmpl_rd_en) bus.tmpl_rd_data <= mem[bus.tmpl_rd_addr];
    else                bus.tmpl_rd_data <= '1;
  end

  typedef struct {
    int           cyc;
    logic [L*P-1:0]   il;
    logic [L*K*P-1:0] tl;
    logic         last;
  } lv_t;

  lv_t lv_q[$];
  int  acc_q[$];
  int  done_q[$];
  int  addr_q[$];

  // Observation of handshakes and line events, sampled mid-cycle.
  always @(negedge CLK) begin
    if (bus.pix_valid && bus.pix_ready) acc_q.push_back(cyc);
    if (bus.line_valid) lv_q.push_back('{cyc, bus.I_out_line, bus.T_out_line, bus.last_line});
    if (bus.done) done_q.push_back(cyc);
    if (bus.tmpl_rd_en) addr_q.push_back(int'(bus.tmpl_rd_addr));
  end

  // Expected image lines: exactly the pixels sent, in order, per row.
  logic [L-1:0][P-1:0] exp_line [H];

  typedef struct {
    int mode;       // 0 continuous, 1 toggled valid, 2 random gaps and pixels
    int start_row;  // row during which a stray start is pulsed, -1 none
    int exp_lines;
    int exp_dones;
  } vec_t;

  vec_t tbl [4];

  task automatic chk(input string nm, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_obs();
    lv_q.delete();
    acc_q.delete();
    done_q.delete();
    addr_q.delete();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_pix_ready"},  TW'(bus.pix_ready), 0);
    chk({tag, "_rd_en"},      TW'(bus.tmpl_rd_en), 0);
    chk({tag, "_line_valid"}, TW'(bus.line_valid), 0);
    chk({tag, "_last_line"},  TW'(bus.last_line), 0);
    chk({tag, "_busy"},       TW'(bus.busy), 0);
    chk({tag, "_done"},       TW'(bus.done), 0);
    chk({tag, "_I_out"},      TW'(bus.I_out_line), 0);
    chk({tag, "_T_out"},      TW'(bus.T_out_line), 0);
  endtask

  task automatic send_pixel(input logic [P-1:0] p, input int gaps, input bit st);
    int w;
    if (gaps > 0) begin
      bus.pix_valid = 0;
      repeat (gaps) begin @(posedge CLK); #1; end
    end
    bus.pix_valid = 1;
    bus.pix_in    = p;
    bus.start     = st;
    w = 0;
    while (!bus.pix_ready && w < 50) begin
      @(posedge CLK); #1;
      w++;
    end
    if (w >= 50) begin
      checks++;
      fails++;
      $display("FAIL pix_ready_timeout: got 0 expected 1");
    end
    @(posedge CLK); #1;
    bus.start     = 0;
    bus.pix_valid = 0;
  endtask

  task automatic run_window(input int mode, input int start_row, input int rows);
    int gaps;
    clear_obs();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < L; c++)
        exp_line[r][c] = (mode == 2) ? P'($urandom) : P'(r * L + c + 1);
    bus.start = 1;
    @(posedge CLK); #1;
    bus.start = 0;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < L; c++) begin
        if (mode == 1)      gaps = (c == 0) ? 0 : 1;
        else if (mode == 2) gaps = $urandom_range(0, 2);
        else                gaps = 0;
        send_pixel(exp_line[r][c], gaps, (r == start_row) && (c == 3));
      end
    end
    // Junk pixel offered while the feeder is not filling.
    bus.pix_valid = 1;
    bus.pix_in    = 8'hEE;
  endtask

  task automatic check_window(input vec_t v, input bit first);
    int n;
    n = lv_q.size();
    chk("line_count", TW'(n), TW'(v.exp_lines));
    for (int r = 0; r < H; r++) begin
      if (r < n) begin
        chk($sformatf("iline_r%0d", r), TW'(lv_q[r].il), TW'(exp_line[r]));
        chk($sformatf("tline_r%0d", r), TW'(lv_q[r].tl), TW'(mem[r]));
        chk($sformatf("last_r%0d", r),  TW'(lv_q[r].last), TW'(r == H - 1));
        if (acc_q.size() > r * L + L - 1)
          chk($sformatf("latency_r%0d", r), TW'(lv_q[r].cyc), TW'(acc_q[r * L + L - 1] + 3));
      end
    end
    chk("accept_count", TW'(acc_q.size()), TW'(H * L));
    chk("done_count", TW'(done_q.size()), TW'(v.exp_dones));
    if (done_q.size() > 0 && n > 0)
      chk("done_timing", TW'(done_q[0]), TW'(lv_q[n - 1].cyc + 1));
    chk("rd_count", TW'(addr_q.size()), TW'(H));
    for (int i = 0; i < addr_q.size() && i < H; i++)
      chk($sformatf("rd_addr_%0d", i), TW'(addr_q[i]), TW'(i));
    chk("busy_after", TW'(bus.busy), 0);
    if (v.mode == 1 && acc_q.size() >= H * L) begin
      chk("toggle_span_r0", TW'(acc_q[L - 1] - acc_q[0]), TW'(2 * (L - 1)));
      chk("toggle_span_r7", TW'(acc_q[H * L - 1] - acc_q[(H - 1) * L]), TW'(2 * (L - 1)));
    end
    if (first && n > 0) begin
      chk("first_iline_const", TW'(lv_q[0].il), TW'(64'h0807060504030201));
      chk("first_tline_const", TW'(lv_q[0].tl), TW'({8{32'hA3A2A1A0}}));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0, -1, 8, 1};
    tbl[1] = '{1, -1, 8, 1};
    tbl[2] = '{0,  3, 8, 1};
    tbl[3] = '{2, -1, 8, 1};

    for (int r = 0; r < H; r++)
      for (int c = 0; c < L; c++)
        for (int k = 0; k < K; k++)
          mem[r][c][k] = (r == 0) ? P'(8'hA0 + k) : P'($urandom);

    RST_N         = 0;
    bus.start     = 0;
    bus.pix_valid = 0;
    bus.pix_in    = '0;
    repeat (2) @(posedge CLK);
    #1;
    check_zero("reset");
    RST_N = 1;
    @(posedge CLK); #1;

    for (int i = 0; i < 4; i++) begin
      run_window(tbl[i].mode, tbl[i].start_row, H);
      repeat (12) @(posedge CLK);
      #1;
      bus.pix_valid = 0;
      check_window(tbl[i], i == 0);
    end

    // Pixels offered while idle are neither accepted nor captured.
    bus.pix_valid = 1;
    bus.pix_in    = 8'h5C;
    clear_obs();
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      chk($sformatf("idle_pix_ready_%0d", i), TW'(bus.pix_ready), 0);
      chk($sformatf("idle_I_out_%0d", i), TW'(bus.I_out_line), TW'(exp_line[H - 1]));
    end
    chk("idle_accepts", TW'(acc_q.size()), 0);
    bus.pix_valid = 0;

    // Reset during WAIT of row 5 abandons the window.
    run_window(0, -1, 6);
    @(posedge CLK); #1;
    RST_N = 0;
    @(posedge CLK); #1;
    check_zero("midreset");
    RST_N = 1;
    repeat (30) @(posedge CLK);
    #1;
    chk("midreset_lines", TW'(lv_q.size()), 5);
    chk("midreset_dones", TW'(done_q.size()), 0);
    chk("midreset_accepts", TW'(acc_q.size()), TW'(6 * L));
    bus.pix_valid = 0;

    run_window(0, -1, H);
    repeat (12) @(posedge CLK);
    #1;
    bus.pix_valid = 0;
    check_window(tbl[0], 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
